udp_tx_scheduler: RTL and testbench

UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

---
 rtl/udp_tx_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/udp_tx_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_udp_tx_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_pkg.sv
// Shared state encoding and default sizing for the UDP transmit scheduler.
package udp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    STREAM,
    DRAIN,
    KICK,
    WAIT_FIN
  } state_e;

  localparam int DEF_N_CLIENTS   = 3;
  localparam int DEF_MAX_LEN     = 1024;
  localparam int DEF_WDOG_CYCLES = 4096;

  // Width of a client index; kept at least 1 so a single-client build still elaborates.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester found at or after ptr_i,
// wrapping from N-1 back to 0. Grant is one-hot, or all-zero when disabled.
module rr_arbiter
  import udp_tx_pkg::*;
#(
  parameter int N  = DEF_N_CLIENTS,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = ptr_i;
    for (int i = 0; i < N; i++) begin
      if (en_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
      idx = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares one UDP generator between several payload clients: round-robin packet
// grant, registered byte forwarding, length truncation and a completion watchdog.
//
// state    | meaning
// IDLE     | no packet owned; wait for any client valid while generator not busy
// ARB      | pick next client round-robin, latch its IP and ports
// STREAM   | forward granted client's bytes to the generator
// DRAIN    | packet exceeded MAX_LEN; swallow bytes until the client's last
// KICK     | payload complete; issue the one-cycle gen_req
// WAIT_FIN | wait for gen_fin or watchdog expiry, then release the client
module udp_tx_scheduler
  import udp_tx_pkg::*;
#(
  parameter int N_CLIENTS   = DEF_N_CLIENTS,
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CLIENTS-1:0]    cl_valid,
  input  logic [8*N_CLIENTS-1:0]  cl_data,
  input  logic [N_CLIENTS-1:0]    cl_last,
  input  logic [32*N_CLIENTS-1:0] cl_ip,
  input  logic [16*N_CLIENTS-1:0] cl_src_port,
  input  logic [16*N_CLIENTS-1:0] cl_dst_port,
  output logic [N_CLIENTS-1:0]    cl_ready,
  output logic [N_CLIENTS-1:0]    cl_done,
  output logic [7:0]              gen_data,
  output logic                    gen_tx_en,
  output logic                    gen_req,
  output logic [31:0]             gen_ip,
  output logic [15:0]             gen_src_port,
  output logic [15:0]             gen_dst_port,
  input  logic                    gen_busy,
  input  logic                    gen_full,
  input  logic                    gen_fin,
  output logic [15:0]             sent_cnt,
  output logic [15:0]             drop_cnt,
  output logic                    wdog_err
);

  localparam int PW = ptr_w(N_CLIENTS);
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  state_e               state_q;
  logic [PW-1:0]        ptr_q;
  logic [N_CLIENTS-1:0] grant_q;
  logic [15:0]          byte_cnt_q;
  logic [15:0]          byte_cnt_d;
  logic [WW-1:0]        wdog_q;
  logic [N_CLIENTS-1:0] cl_done_q;
  logic [7:0]           gen_data_q;
  logic                 gen_tx_en_q;
  logic                 gen_req_q;
  logic [31:0]          gen_ip_q;
  logic [15:0]          gen_src_port_q;
  logic [15:0]          gen_dst_port_q;
  logic [15:0]          sent_cnt_q;
  logic [15:0]          drop_cnt_q;
  logic                 wdog_err_q;

  logic [N_CLIENTS-1:0] arb_grant;
  logic [PW-1:0]        arb_next_ptr;
  logic [31:0]          arb_ip;
  logic [15:0]          arb_src;
  logic [15:0]          arb_dst;
  logic [7:0]           sel_data;
  logic                 sel_last;
  logic                 accept;

  rr_arbiter #(
    .N  (N_CLIENTS),
    .PW (PW)
  ) u_rr_arbiter (
    .req_i   (cl_valid),
    .ptr_i   (ptr_q),
    .en_i    (state_q == ARB),
    .grant_o (arb_grant)
  );

  // grant_q selects the streaming client; arb_grant selects the one being latched.
  always_comb begin
    sel_data     = '0;
    sel_last     = 1'b0;
    arb_ip       = '0;
    arb_src      = '0;
    arb_dst      = '0;
    arb_next_ptr = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant_q[i]) begin
        sel_data = cl_data[8*i +: 8];
        sel_last = cl_last[i];
      end
      if (arb_grant[i]) begin
        arb_ip       = cl_ip[32*i +: 32];
        arb_src      = cl_src_port[16*i +: 16];
        arb_dst      = cl_dst_port[16*i +: 16];
        arb_next_ptr = (i == N_CLIENTS - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_comb begin
    cl_ready = '0;
    if (state_q == STREAM) begin
      cl_ready = grant_q & {N_CLIENTS{!gen_full && !gen_busy}};
    end else if (state_q == DRAIN) begin
      cl_ready = grant_q;
    end
  end

  assign accept     = |(cl_valid & cl_ready);
  assign byte_cnt_d = byte_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      grant_q        <= '0;
      byte_cnt_q     <= '0;
      wdog_q         <= '0;
      cl_done_q      <= '0;
      gen_data_q     <= '0;
      gen_tx_en_q    <= 1'b0;
      gen_req_q      <= 1'b0;
      gen_ip_q       <= '0;
      gen_src_port_q <= '0;
      gen_dst_port_q <= '0;
      sent_cnt_q     <= '0;
      drop_cnt_q     <= '0;
      wdog_err_q     <= 1'b0;
    end else begin
      gen_tx_en_q <= 1'b0;
      gen_req_q   <= 1'b0;
      cl_done_q   <= '0;
      wdog_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|cl_valid && !gen_busy) state_q <= ARB;
        end
        ARB: begin
          // A client may withdraw between IDLE and ARB; fall back rather than stall.
          if (|arb_grant) begin
            grant_q        <= arb_grant;
            ptr_q          <= arb_next_ptr;
            gen_ip_q       <= arb_ip;
            gen_src_port_q <= arb_src;
            gen_dst_port_q <= arb_dst;
            byte_cnt_q     <= '0;
            state_q        <= STREAM;
          end else begin
            state_q <= IDLE;
          end
        end
        STREAM: begin
          if (accept) begin
            gen_data_q  <= sel_data;
            gen_tx_en_q <= 1'b1;
            byte_cnt_q  <= byte_cnt_d;
            if (sel_last) begin
              state_q <= KICK;
            end else if (byte_cnt_d == 16'(MAX_LEN)) begin
              drop_cnt_q <= drop_cnt_q + 16'd1;
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (accept && sel_last) state_q <= KICK;
        end
        KICK: begin
          gen_req_q <= 1'b1;
          wdog_q    <= WW'(WDOG_CYCLES);
          state_q   <= WAIT_FIN;
        end
        WAIT_FIN: begin
          if (gen_fin) begin
            cl_done_q  <= grant_q;
            sent_cnt_q <= sent_cnt_q + 16'd1;
            state_q    <= IDLE;
          end else if (wdog_q == WW'(1)) begin
            cl_done_q  <= grant_q;
            wdog_err_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            wdog_q <= wdog_q - WW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cl_done      = cl_done_q;
  assign gen_data     = gen_data_q;
  assign gen_tx_en    = gen_tx_en_q;
  assign gen_req      = gen_req_q;
  assign gen_ip       = gen_ip_q;
  assign gen_src_port = gen_src_port_q;
  assign gen_dst_port = gen_dst_port_q;
  assign sent_cnt     = sent_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign wdog_err     = wdog_err_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler: tests queue expected bytes, requests
// and completions; a negedge monitor pops and compares as the DUT presents them.
module tb_udp_tx_scheduler;

  localparam int N    = 3;
  localparam int MAXL = 1024;
  localparam int WDOG = 4096;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    cl_valid = '0;
  logic [8*N-1:0]  cl_data = '0;
  logic [N-1:0]    cl_last = '0;
  logic [32*N-1:0] cl_ip = '0;
  logic [16*N-1:0] cl_src_port = '0;
  logic [16*N-1:0] cl_dst_port = '0;
  logic [N-1:0]    cl_ready;
  logic [N-1:0]    cl_done;
  logic [7:0]      gen_data;
  logic            gen_tx_en;
  logic            gen_req;
  logic [31:0]     gen_ip;
  logic [15:0]     gen_src_port;
  logic [15:0]     gen_dst_port;
  logic            gen_busy = 1'b0;
  logic            gen_full = 1'b0;
  logic            gen_fin = 1'b0;
  logic [15:0]     sent_cnt;
  logic [15:0]     drop_cnt;
  logic            wdog_err;

  udp_tx_scheduler #(
    .N_CLIENTS   (N),
    .MAX_LEN     (MAXL),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cl_valid     (cl_valid),
    .cl_data      (cl_data),
    .cl_last      (cl_last),
    .cl_ip        (cl_ip),
    .cl_src_port  (cl_src_port),
    .cl_dst_port  (cl_dst_port),
    .cl_ready     (cl_ready),
    .cl_done      (cl_done),
    .gen_data     (gen_data),
    .gen_tx_en    (gen_tx_en),
    .gen_req      (gen_req),
    .gen_ip       (gen_ip),
    .gen_src_port (gen_src_port),
    .gen_dst_port (gen_dst_port),
    .gen_busy     (gen_busy),
    .gen_full     (gen_full),
    .gen_fin      (gen_fin),
    .sent_cnt     (sent_cnt),
    .drop_cnt     (drop_cnt),
    .wdog_err     (wdog_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int bytes_seen = 0;
  int wdog_cnt = 0;
  bit byte_chk_en = 1'b1;
  bit fin_en = 1'b1;
  bit wdog_exp = 1'b0;
  bit abort_drv = 1'b0;

  logic [7:0] exp_byte_q[$];
  int         exp_req_q[$];
  int         exp_done_q[$];

  always @(posedge clk) cyc++;

  function automatic logic [31:0] ip_of(input int c);
    return 32'hC0A8_0100 + 32'(c);
  endfunction
  function automatic logic [15:0] src_of(input int c);
    return 16'h1000 + 16'(c);
  endfunction
  function automatic logic [15:0] dst_of(input int c);
    return 16'h2000 + 16'(c);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int c;
    if (gen_tx_en) begin
      bytes_seen++;
      if (byte_chk_en) begin
        if (exp_byte_q.size() == 0) fail_now("byte_extra", 64'(gen_data));
        else check("byte_data", 64'(gen_data), 64'(exp_byte_q.pop_front()));
      end
    end
    if (gen_req) begin
      req_cyc = cyc;
      check("req_no_tx_en", 64'(gen_tx_en), 64'd0);
      if (exp_req_q.size() == 0) fail_now("req_extra", 64'(gen_ip));
      else begin
        c = exp_req_q.pop_front();
        check("req_ip", 64'(gen_ip), 64'(ip_of(c)));
        check("req_src", 64'(gen_src_port), 64'(src_of(c)));
        check("req_dst", 64'(gen_dst_port), 64'(dst_of(c)));
      end
    end
    if (|cl_done) begin
      if (exp_done_q.size() == 0) fail_now("done_extra", 64'(cl_done));
      else begin
        c = exp_done_q.pop_front();
        check("done_client", 64'(cl_done), 64'(1) << c);
      end
    end
    if (wdog_err) begin
      wdog_cnt++;
      check("wdog_expected", 64'(wdog_exp), 64'd1);
      check("wdog_delay", 64'(cyc - req_cyc), 64'(WDOG));
    end
  end

  // Generator model: answers each gen_req with gen_fin two cycles later.
  always begin
    @(negedge clk);
    if (gen_req && fin_en) begin
      repeat (2) @(negedge clk);
      gen_fin = 1'b1;
      @(negedge clk);
      gen_fin = 1'b0;
    end
  end

  task automatic drive_byte(input int c, input logic [7:0] d, input logic last);
    bit took = 1'b0;
    int n = 0;
    @(negedge clk);
    if (!abort_drv) begin
      cl_valid[c]        = 1'b1;
      cl_data[8*c +: 8]  = d;
      cl_last[c]         = last;
      while (!took && !abort_drv) begin
        #1;
        if (cl_ready[c]) took = 1'b1;
        else begin
          n++;
          if (n > 10000) begin
            fail_now("ready_timeout", 64'(c));
            took = 1'b1;
          end else @(negedge clk);
        end
      end
    end
  endtask

  task automatic send_pkt(input int c, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) drive_byte(c, base + 8'(i), i == n - 1);
    @(negedge clk);
    cl_valid[c] = 1'b0;
    cl_last[c]  = 1'b0;
  endtask

  task automatic expect_pkt(input int c, input int n, input logic [7:0] base);
    for (int i = 0; i < n && i < MAXL; i++) exp_byte_q.push_back(base + 8'(i));
    exp_req_q.push_back(c);
    exp_done_q.push_back(c);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (exp_done_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_drained"}, 64'(exp_done_q.size()), 64'd0);
    check({name, "_bytes_drained"}, 64'(exp_byte_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int s0;
    int n;
    logic [15:0] sent_before;
    for (int c = 0; c < N; c++) begin
      cl_ip[32*c +: 32]       = ip_of(c);
      cl_src_port[16*c +: 16] = src_of(c);
      cl_dst_port[16*c +: 16] = dst_of(c);
    end
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_en", 64'(gen_tx_en), 64'd0);
    check("rst_req", 64'(gen_req), 64'd0);
    check("rst_ip", 64'(gen_ip), 64'd0);
    check("rst_ready", 64'(cl_ready), 64'd0);
    check("rst_sent", 64'(sent_cnt), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b1;

    // Single 5-byte packet from client 1
    s0 = bytes_seen;
    expect_pkt(1, 5, 8'h01);
    send_pkt(1, 5, 8'h01);
    wait_done("t1", 200);
    check("t1_tx_cycles", 64'(bytes_seen - s0), 64'd5);
    check("t1_sent", 64'(sent_cnt), 64'd1);

    // Async reset in the middle of a client 2 packet
    byte_chk_en = 1'b0;
    s0 = bytes_seen;
    fork
      send_pkt(2, 20, 8'h80);
      begin
        n = 0;
        while (bytes_seen < s0 + 4 && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("t6_streaming", 64'(bytes_seen >= s0 + 4), 64'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("t6_data", 64'(gen_data), 64'd0);
        check("t6_tx_en", 64'(gen_tx_en), 64'd0);
        check("t6_ip", 64'(gen_ip), 64'd0);
        check("t6_ports", 64'({gen_src_port, gen_dst_port}), 64'd0);
        check("t6_ready", 64'(cl_ready), 64'd0);
        check("t6_sent", 64'(sent_cnt), 64'd0);
        abort_drv = 1'b1;
        cl_valid  = '0;
        cl_last   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
      end
    join
    abort_drv = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_req_left", 64'(exp_req_q.size()), 64'd0);
    byte_chk_en = 1'b1;

    // Three clients at once, client 0 asks again: expect 0,1,2,0
    expect_pkt(0, 3, 8'h10);
    expect_pkt(1, 4, 8'h20);
    expect_pkt(2, 2, 8'h30);
    expect_pkt(0, 3, 8'h40);
    fork
      begin
        send_pkt(0, 3, 8'h10);
        send_pkt(0, 3, 8'h40);
      end
      send_pkt(1, 4, 8'h20);
      send_pkt(2, 2, 8'h30);
    join
    wait_done("t2", 500);
    check("t2_sent", 64'(sent_cnt), 64'd4);

    // gen_full held for 10 cycles around byte 3 of 8
    s0 = bytes_seen;
    expect_pkt(0, 8, 8'h50);
    fork
      send_pkt(0, 8, 8'h50);
      begin
        n = 0;
        while (bytes_seen < s0 + 2 && n < 200) begin
          @(negedge clk);
          n++;
        end
        gen_full = 1'b1;
        repeat (10) @(negedge clk);
        gen_full = 1'b0;
      end
    join
    wait_done("t3", 200);
    check("t3_tx_cycles", 64'(bytes_seen - s0), 64'd8);
    check("t3_sent", 64'(sent_cnt), 64'd5);

    // 1030-byte packet truncated at MAX_LEN
    s0 = bytes_seen;
    expect_pkt(2, 1030, 8'h00);
    send_pkt(2, 1030, 8'h00);
    wait_done("t4", 500);
    check("t4_tx_cycles", 64'(bytes_seen - s0), 64'(MAXL));
    check("t4_drop", 64'(drop_cnt), 64'd1);
    check("t4_sent", 64'(sent_cnt), 64'd6);

    // Generator never finishes: watchdog
    fin_en      = 1'b0;
    wdog_exp    = 1'b1;
    sent_before = sent_cnt;
    expect_pkt(1, 3, 8'hA0);
    send_pkt(1, 3, 8'hA0);
    wait_done("t5", WDOG + 500);
    check("t5_wdog_pulses", 64'(wdog_cnt), 64'd1);
    check("t5_sent_unchanged", 64'(sent_cnt), 64'(sent_before));
    fin_en   = 1'b1;
    wdog_exp = 1'b0;
    expect_pkt(0, 4, 8'hC0);
    send_pkt(0, 4, 8'hC0);
    wait_done("t5b", 200);
    check("t5b_sent", 64'(sent_cnt), 64'd7);
    check("t5b_wdog_pulses", 64'(wdog_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
